// File: rtl/brg_multi.sv
// Baud-rate generator with a double-buffered divisor, oversample tick (brg_en) and bit tick (brg_full).
// Define BRG_FRAC_EN to add the fractional-divisor accumulator (ioaddr=01 loads the fraction).
module brg_multi #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic [1:0]        ioaddr,
  input  logic [DATA_W-1:0] databus,
  input  logic              rx_sync,
  output logic              brg_en,
  output logic              brg_full,
  output logic              brg_active
);

  localparam int HI_W = DIV_W - DATA_W;
  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);

  logic [HI_W-1:0]  hi_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [OS_W-1:0]  os_reg;

  logic             hi_wr;
  logic             lo_wr;
  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] reload_val;

  assign hi_wr   = iocs && (ioaddr == 2'b11);
  assign lo_wr   = iocs && (ioaddr == 2'b10);
  assign new_div = {hi_reg, databus};

`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] frac_reg;
  logic [FRAC_W-1:0] acc_reg;
  logic [FRAC_W:0]   acc_sum;
  logic              frac_wr;

  assign frac_wr = iocs && (ioaddr == 2'b01);
  assign acc_sum = {1'b0, acc_reg} + {1'b0, frac_reg};
  // A carry out of the accumulator stretches the coming period by one cycle.
  assign reload_val = acc_sum[FRAC_W] ? div_reg : div_reg - DIV_W'(1);
`else
  assign reload_val = div_reg - DIV_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg     <= '0;
      div_reg    <= '0;
      cnt_reg    <= '0;
      os_reg     <= '0;
      brg_en     <= 1'b0;
      brg_full   <= 1'b0;
      brg_active <= 1'b0;
`ifdef BRG_FRAC_EN
      frac_reg   <= '0;
      acc_reg    <= '0;
`endif
    end else begin
      brg_en   <= 1'b0;
      brg_full <= 1'b0;

      if (hi_wr) hi_reg <= HI_W'(databus);
`ifdef BRG_FRAC_EN
      if (frac_wr) frac_reg <= databus[FRAC_W-1:0];
`endif

      // Commit beats rx_sync and any pending tick on the same edge.
      if (lo_wr) begin
        div_reg    <= new_div;
        brg_active <= (new_div != '0);
        cnt_reg    <= (new_div == '0) ? '0 : new_div - DIV_W'(1);
        os_reg     <= '0;
`ifdef BRG_FRAC_EN
        acc_reg    <= '0;
`endif
      end else if (div_reg == '0) begin
        cnt_reg <= '0;
        os_reg  <= '0;
      end else if (rx_sync) begin
        os_reg  <= OS_MID;
        cnt_reg <= div_reg - DIV_W'(1);
      end else if (cnt_reg == '0) begin
        brg_en  <= 1'b1;
        cnt_reg <= reload_val;
`ifdef BRG_FRAC_EN
        acc_reg <= acc_sum[FRAC_W-1:0];
`endif
        if (os_reg == OS_LAST) begin
          os_reg   <= '0;
          brg_full <= 1'b1;
        end else begin
          os_reg <= os_reg + OS_W'(1);
        end
      end else begin
        cnt_reg <= cnt_reg - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_brg_multi.sv
// Self-checking bench for brg_multi: directed timing scenarios plus random bus/sync traffic
// compared each cycle against an event-scheduling reference model.
module tb_brg_multi;

  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       iocs;
  logic [1:0] ioaddr;
  logic [7:0] databus;
  logic       rx_sync;
  logic       brg_en;
  logic       brg_full;
  logic       brg_active;

  brg_multi dut (
    .clk       (clk),
    .rst       (rst),
    .iocs      (iocs),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .rx_sync   (rx_sync),
    .brg_en    (brg_en),
    .brg_full  (brg_full),
    .brg_active(brg_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int full_cnt = 0;

  // Reference model: absolute cycle of the next scheduled tick and tick index within a bit.
  int m_hi, m_div, m_next, m_idx, m_frac, m_acc;
  bit e_en, e_full, e_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit cs, input bit [1:0] a,
                                     input bit [7:0] d, input bit sy);
    int period;
    e_en   = 1'b0;
    e_full = 1'b0;
    if (r) begin
      m_hi = 0; m_div = 0; m_next = 0; m_idx = 0; m_frac = 0; m_acc = 0;
      e_active = 1'b0;
      return;
    end
    if (cs && a == 2'b10) begin
      m_div    = m_hi * 256 + d;
      e_active = (m_div != 0);
      m_idx    = 0;
      m_acc    = 0;
      m_next   = cyc + m_div;
    end else if (m_div != 0) begin
      if (sy) begin
        m_idx  = OS / 2;
        m_next = cyc + m_div;
      end else if (cyc == m_next) begin
        e_en   = 1'b1;
        e_full = (m_idx == OS - 1);
        m_idx  = (m_idx + 1) % OS;
        period = m_div;
`ifdef BRG_FRAC_EN
        if (m_acc + m_frac >= 16) period = period + 1;
        m_acc = (m_acc + m_frac) % 16;
`endif
        m_next = cyc + period;
      end
    end
    if (cs && a == 2'b11) m_hi = d;
`ifdef BRG_FRAC_EN
    if (cs && a == 2'b01) m_frac = d % 16;
`endif
  endfunction

  task automatic cycle(input bit r, input bit cs, input bit [1:0] a, input bit [7:0] d, input bit sy);
    rst = r; iocs = cs; ioaddr = a; databus = d; rx_sync = sy;
    @(posedge clk);
    cyc++;
    model_edge(r, cs, a, d, sy);
    #1;
    check($sformatf("en@%0d", cyc), brg_en, e_en);
    check($sformatf("full@%0d", cyc), brg_full, e_full);
    check($sformatf("active@%0d", cyc), brg_active, e_active);
    if (brg_en === 1'b1) en_cnt++;
    if (brg_full === 1'b1) full_cnt++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    $display("wr addr=%b data=%02h cyc=%0d", a, d, cyc + 1);
    cycle(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic wait_en(input int budget, output int at);
    at = -100000;
    for (int i = 0; i < budget; i++) begin
      idle();
      if (brg_en === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_full(input int budget, output int at);
    at = -100000;
    for (int i = 0; i < budget; i++) begin
      idle();
      if (brg_full === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, t, t2, n0, f0;
    bit r, cs, sy;
    bit [1:0] a;
    bit [7:0] d;

    rst = 1'b1; iocs = 1'b0; ioaddr = 2'b00; databus = 8'h00; rx_sync = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
    check("rst_en", brg_en, 0);
    check("rst_active", brg_active, 0);

    // 1: divisor 0x000F
    wr(2'b11, 8'h00);
    wr(2'b10, 8'h0F);
    c0 = cyc;
    check("t1_active", brg_active, 1);
    wait_en(20, t);
    check("t1_first_en", t - c0, 15);
    wait_en(20, t2);
    check("t1_en_period", t2 - t, 15);
    wait_full(300, t);
    check("t1_first_full", t - c0, 240);
    wait_full(300, t2);
    check("t1_full_period", t2 - t, 240);

    // 2: divisor 1, then 0
    wr(2'b10, 8'h01);
    n0 = en_cnt; f0 = full_cnt;
    repeat (32) idle();
    check("t2_en_count", en_cnt - n0, 32);
    check("t2_full_count", full_cnt - f0, 2);
    wr(2'b10, 8'h00);
    n0 = en_cnt; f0 = full_cnt;
    repeat (8) idle();
    check("t2_idle_en", en_cnt - n0, 0);
    check("t2_idle_full", full_cnt - f0, 0);
    check("t2_idle_active", brg_active, 0);

    // 3: staged hi write leaves cadence alone until lo commits
    wr(2'b10, 8'h0F);
    wait_en(20, t);
    wr(2'b11, 8'h01);
    wait_en(20, t2);
    check("t3_cadence", t2 - t, 15);
    wr(2'b10, 8'h00);
    c0 = cyc;
    wait_en(300, t);
    check("t3_first_en", t - c0, 256);
    wait_full(5000, t);
    check("t3_first_full", t - c0, 4096);

    // 4: rx_sync realignment, then sync coinciding with a commit
    wr(2'b11, 8'h00);
    wr(2'b10, 8'h04);
    repeat (10) idle();
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
    c0 = cyc;
    wait_en(10, t);
    check("t4_sync_en", t - c0, 4);
    wait_full(64, t);
    check("t4_sync_full", t - c0, 32);
    repeat (5) idle();
    cycle(1'b0, 1'b1, 2'b10, 8'h05, 1'b1);
    c0 = cyc;
    wait_en(10, t);
    check("t4_commit_en", t - c0, 5);
    wait_full(200, t);
    check("t4_commit_full", t - c0, 80);

    // 5: reset while a tick is about to fire
    wr(2'b10, 8'h03);
    idle();
    idle();
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
    check("t5_en_after_rst", brg_en, 0);
    n0 = en_cnt;
    repeat (10) idle();
    check("t5_en_quiet", en_cnt - n0, 0);
    check("t5_active", brg_active, 0);

    // 6: fractional divisor 10 + 8/16
    wr(2'b11, 8'h00);
    wr(2'b01, 8'h08);
    wr(2'b10, 8'h0A);
    wait_en(20, t);
    t2 = t;
    for (int i = 0; i < 16; i++) wait_en(20, t2);
`ifdef BRG_FRAC_EN
    check("t6_16_periods", t2 - t, 168);
`else
    check("t6_16_periods", t2 - t, 160);
`endif

    // Random traffic against the model
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      cs = ($urandom_range(0, 29) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == 2'b11)      d = 8'($urandom_range(0, 1));
      else if (a == 2'b10) d = 8'($urandom_range(0, 40));
      else                 d = 8'($urandom);
      sy = ($urandom_range(0, 39) == 0);
      if (cs) $display("wr addr=%b data=%02h sync=%0d cyc=%0d", a, d, sy, cyc + 1);
      cycle(r, cs, a, d, sy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brg_multi.md
Name: brg_multi

Overview:
- Parametrised successor to the SPART baud-rate generator: programmable 16-bit divisor loaded over the 8-bit I/O bus, producing an oversample tick (brg_en) and a bit tick (brg_full).
- Adds a double-buffered divisor with atomic commit, a configurable oversample ratio, a zero-divisor disable, and receiver re-alignment (rx_sync) for mid-bit sampling.
- Sits between the SPART bus decoder and the TX/RX shift engines.

Parameters:
- DATA_W, 8, I/O bus width.
- DIV_W, 16, divisor width; the hi byte holds bits DIV_W-1:DATA_W, and excess databus bits are dropped.
- OVERSAMPLE, 16, brg_en ticks per brg_full tick; must be >= 2.
- FRAC_W, 4, fractional divisor width; only used when BRG_FRAC_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- iocs  in  1  chip select; register writes occur only when iocs=1
- ioaddr  in  2  11=divisor hi, 10=divisor lo (commit), 01=fraction, 00=ignored
- databus  in  DATA_W  write data
- rx_sync  in  1  single-cycle pulse; re-aligns the oversample phase to a start edge
- brg_en  out  1  one-cycle oversample tick
- brg_full  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th brg_en
- brg_active  out  1  1 when the committed divisor is non-zero

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Reset takes effect on the clk edge where rst=1.
- Reset values: brg_en=0, brg_full=0, brg_active=0. Staging hi=0, committed divisor=0, down-counter=0, oversample counter=0, fraction=0, accumulator=0.
- Hi write (iocs & ioaddr=11):
  - Loads the staging hi register only.
  - Running output cadence is unchanged.
- Lo write (iocs & ioaddr=10): commits {staging hi, databus} into the divisor on that edge. On the same edge:
  - down-counter <= new divisor - 1
  - oversample counter <= 0
  - fractional accumulator <= 0
- Writes with iocs=0 or ioaddr=00 are ignored.
- Down-counter, when the divisor D != 0:
  - decrements each cycle;
  - at 0 it reloads D-1 and brg_en is registered high for the next cycle;
  - period = D cycles; the first brg_en follows the committing edge by D cycles;
  - D=1 gives brg_en high on every cycle.
- D=0: generator idle. Counter held at 0; brg_en, brg_full and brg_active stay 0.
- Oversample counter:
  - increments on each brg_en tick, wrapping at OVERSAMPLE-1 -> 0;
  - brg_full=1 in the same cycle as the brg_en that wraps it, so the first brg_full is the OVERSAMPLE-th brg_en after a commit.
- rx_sync=1:
  - oversample counter <= OVERSAMPLE/2 and down-counter <= D-1;
  - the next brg_full therefore arrives OVERSAMPLE/2 ticks later (mid-bit);
  - ignored when D=0.
- Simultaneous events:
  - lo-commit and rx_sync in the same cycle: the commit wins and rx_sync is dropped;
  - hi write and lo write cannot coincide (single ioaddr).
- Reset mid-operation: all state returns to reset values and the divisor must be reprogrammed.
- Outputs are registered, with no combinational path from inputs.

Optional Feature:
- Macro: BRG_FRAC_EN
- Defined:
  - an ioaddr=01 write loads fraction F <= databus[FRAC_W-1:0];
  - on each reload, acc <= acc + F (FRAC_W bits);
  - on carry-out, the next period is D+1 cycles, else D;
  - average period = D + F/2^FRAC_W;
  - a fraction write takes effect at the next reload, and acc clears on lo-commit.
- Not defined: ioaddr=01 writes are ignored, no fraction or accumulator logic exists, and the period is exactly D.

Test Plan:
1. Reset, then write hi=00, then lo=0F -> brg_active=1 next cycle; brg_en pulses every 15 cycles; brg_full on the 16th brg_en (240 cycles after commit), then every 240 cycles.
2. Divisor 0x0001 -> brg_en constant 1; brg_full every 16 cycles. Then commit 0x0000 -> brg_en, brg_full and brg_active held 0 from the following cycle.
3. Running at 0x000F, write hi=01 only -> cadence still 15 cycles. Then write lo=00 -> period becomes 256 cycles and the oversample phase restarts.
4. At 0x0004, pulse rx_sync -> brg_en 4 cycles later; brg_full after 8 further ticks (32 cycles after sync). Assert rx_sync with iocs/ioaddr=10 on the same cycle -> commit timing only.
5. Assert rst mid-count with brg_en pending -> no brg_en on the next cycle; all outputs 0 until reprogrammed.
6. (BRG_FRAC_EN) D=0x000A, F=8 (FRAC_W=4) -> brg_en periods alternate 10 and 11 cycles; 16 periods total 168 cycles. Without the macro, the same writes give 160 cycles.
